// File: rtl/awb_gain.sv
// Gray-world auto-white-balance gain calculator: K_X = (R+G+B)/3 / X, via three lockstep
// restoring dividers. Define AWB_GAIN_CLIP_EN to clamp every gain to 4.0.
module awb_gain #(
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  r_mean_i,
  input  logic [7:0]  g_mean_i,
  input  logic [7:0]  b_mean_i,
  output logic [15:0] K_R_o,
  output logic [15:0] K_G_o,
  output logic [15:0] K_B_o,
  output logic        finish_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StDiv, StDone} state_e;

`ifdef AWB_GAIN_CLIP_EN
  localparam logic [15:0] GainMax = 16'(4 << FRAC_BITS);
`endif

  state_e state_q, state_d;

  // Channel index 0 = red, 1 = green, 2 = blue.
  logic [2:0][7:0]  mean_q;
  logic [15:0]      num_q;
  logic [3:0]       iter_q;
  logic [2:0][9:0]  div_q;
  logic [2:0][9:0]  rem_q;
  logic [2:0][9:0]  rem_d;
  logic [2:0]       zero_q;
  logic [2:0][14:0] quo_q;
  logic [2:0][15:0] quo_d;
  logic [2:0][15:0] gain;
  logic [2:0][15:0] k_q;
  logic             finish_q;

  logic [9:0]  sum;
  logic [17:0] numer;
  logic [10:0] trial;

  assign sum   = 10'(mean_q[0]) + 10'(mean_q[1]) + 10'(mean_q[2]);
  assign numer = 18'(sum) << FRAC_BITS;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_i) state_d = StLoad;
      StLoad:  state_d = StDiv;
      StDiv:   if (iter_q == 4'd15) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One restoring-division step per channel; the shared numerator shifts out MSB first.
  always_comb begin
    trial = '0;
    rem_d = '0;
    quo_d = '0;
    gain  = '0;
    for (int c = 0; c < 3; c++) begin
      trial = {rem_q[c], num_q[15]};
      if (trial >= {1'b0, div_q[c]}) begin
        rem_d[c] = 10'(trial - {1'b0, div_q[c]});
        quo_d[c] = {quo_q[c], 1'b1};
      end else begin
        rem_d[c] = trial[9:0];
        quo_d[c] = {quo_q[c], 1'b0};
      end
`ifdef AWB_GAIN_CLIP_EN
      if (zero_q[c] || (quo_d[c] > GainMax)) begin
        gain[c] = GainMax;
      end else begin
        gain[c] = quo_d[c];
      end
`else
      gain[c] = zero_q[c] ? 16'hFFFF : quo_d[c];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mean_q   <= '0;
      num_q    <= '0;
      iter_q   <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      zero_q   <= '0;
      quo_q    <= '0;
      k_q      <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (valid_i) mean_q <= {b_mean_i, g_mean_i, r_mean_i};
        end
        StLoad: begin
          num_q  <= numer[15:0];
          iter_q <= '0;
          quo_q  <= '0;
          for (int c = 0; c < 3; c++) begin
            div_q[c]  <= 10'(mean_q[c]) * 10'd3;
            zero_q[c] <= (mean_q[c] == 8'd0);
            // Top two numerator bits seed the remainder; they are always below the divisor.
            rem_q[c]  <= {8'd0, numer[17:16]};
          end
        end
        StDiv: begin
          num_q  <= {num_q[14:0], 1'b0};
          iter_q <= iter_q + 4'd1;
          rem_q  <= rem_d;
          for (int c = 0; c < 3; c++) begin
            quo_q[c] <= quo_d[c][14:0];
          end
          // The final quotient bit is taken combinationally so gains are valid in DONE.
          if (iter_q == 4'd15) begin
            k_q      <= gain;
            finish_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign K_R_o    = k_q[0];
  assign K_G_o    = k_q[1];
  assign K_B_o    = k_q[2];
  assign finish_o = finish_q;

endmodule

// File: tb/tb_awb_gain.sv
// Scoreboard bench for awb_gain: driver pushes reference gains, monitor checks on finish_o.
module tb_awb_gain;

  localparam int unsigned FRAC_BITS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [7:0]  r_mean = '0;
  logic [7:0]  g_mean = '0;
  logic [7:0]  b_mean = '0;
  logic [15:0] k_r, k_g, k_b;
  logic        finish;

  awb_gain #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .r_mean_i (r_mean),
    .g_mean_i (g_mean),
    .b_mean_i (b_mean),
    .K_R_o    (k_r),
    .K_G_o    (k_g),
    .K_B_o    (k_b),
    .finish_o (finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kr;
    int kg;
    int kb;
    int due;
  } exp_t;

  exp_t sb[$];
  int   held_r = 0, held_g = 0, held_b = 0;
  int   n_cmp = 0, n_err = 0;
  int   free_edge = 0;

  function automatic int ref_gain(int x, int s);
    int q;
    if (x == 0) q = 65535;
    else q = (s * (1 << FRAC_BITS)) / (3 * x);
`ifdef AWB_GAIN_CLIP_EN
    if (q > (4 << FRAC_BITS)) q = 4 << FRAC_BITS;
`endif
    return q;
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle of stimulus; the DUT samples it at edge cyc+1.
  task automatic drive(bit v, int rr, int gg, int bb, bit rs);
    exp_t e;
    @(negedge clk);
    rst     = rs;
    valid_i = v;
    r_mean  = 8'(rr);
    g_mean  = 8'(gg);
    b_mean  = 8'(bb);
    if (rs) begin
      sb.delete();
      held_r    = 0;
      held_g    = 0;
      held_b    = 0;
      free_edge = 0;
    end else if (v && (cyc + 1 >= free_edge)) begin
      e.kr  = ref_gain(rr, rr + gg + bb);
      e.kg  = ref_gain(gg, rr + gg + bb);
      e.kb  = ref_gain(bb, rr + gg + bb);
      e.due = cyc + 1 + 17;
      sb.push_back(e);
      free_edge = cyc + 1 + 19;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  function automatic int rnd_mean();
    if ($urandom_range(0, 7) == 0) return 0;
    return int'($urandom_range(0, 255));
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= 1) begin
        if (finish === 1'b1) begin
          if (sb.size() == 0) begin
            check("spurious_finish", 1, 0);
          end else begin
            e = sb.pop_front();
            check("finish_latency", cyc, e.due);
            held_r = e.kr;
            held_g = e.kg;
            held_b = e.kb;
          end
        end else begin
          if (sb.size() > 0 && cyc >= sb[0].due) begin
            e = sb.pop_front();
            check("missing_finish", 0, 1);
            held_r = e.kr;
            held_g = e.kg;
            held_b = e.kb;
          end
        end
        check("K_R_o", int'(k_r), held_r);
        check("K_G_o", int'(k_g), held_g);
        check("K_B_o", int'(k_b), held_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d expected results pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with valid held high: no pulse, outputs zero.
    drive(1'b1, 10, 20, 30, 1'b1);
    drive(1'b1, 10, 20, 30, 1'b1);
    drive(1'b0, 0, 0, 0, 1'b0);
    idle(3);

    drive(1'b1, 50, 100, 50, 1'b0);
    idle(25);
    drive(1'b1, 128, 128, 128, 1'b0);
    idle(20);
    drive(1'b1, 255, 255, 255, 1'b0);
    idle(20);
    drive(1'b1, 0, 90, 30, 1'b0);
    idle(20);

    // Back-to-back with means changing every cycle.
    for (int i = 0; i < 45; i++) drive(1'b1, rnd_mean(), rnd_mean(), rnd_mean(), 1'b0);
    idle(20);

    // Reset landing in the eighth DIV cycle, then a fresh start.
    drive(1'b1, 40, 80, 120, 1'b0);
    idle(8);
    drive(1'b1, 40, 80, 120, 1'b1);
    drive(1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 200, 1, 3, 1'b0);
    idle(20);

    // Random traffic with occasional resets.
    for (int i = 0; i < 900; i++) begin
      drive($urandom_range(0, 2) == 0, rnd_mean(), rnd_mean(), rnd_mean(),
            $urandom_range(0, 299) == 0);
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    idle(2);
    if (sb.size() != 0) check("drain_pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/awb_gain.md
Name: awb_gain

Overview:
- Gray-world auto-white-balance gain calculator for the ISP statistics path.
- Takes per-frame R, G and B channel means and computes three fixed-point channel gains: K_X = (R+G+B)/3 / X_mean.
- Gains feed the downstream per-pixel gain multiplier.
- Uses a multi-cycle sequential divider, with three channels computed in parallel.

Parameters:
- FRAC_BITS, 8, fractional bits of the output gains (unsigned Q(16-FRAC_BITS).FRAC_BITS); legal range 4..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  means valid; start request.
- r_mean_i  input  8  red channel mean, unsigned.
- g_mean_i  input  8  green channel mean, unsigned.
- b_mean_i  input  8  blue channel mean, unsigned.
- K_R_o  output  16  red gain, unsigned fixed point.
- K_G_o  output  16  green gain.
- K_B_o  output  16  blue gain.
- finish_o  output  1  one-cycle pulse: gains updated.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state: FSM=IDLE, K_R_o=K_G_o=K_B_o=0, finish_o=0, all internal registers cleared. Reset mid-computation aborts it; outputs return to 0.
- FSM states: IDLE, LOAD, DIV, DONE. All outputs are registered.
- IDLE: valid_i sampled high -> capture r/g/b means into registers, go to LOAD. valid_i low -> stay in IDLE.
- LOAD (1 cycle):
  - S = R+G+B (10 bits).
  - Numerator N = S << FRAC_BITS (18 bits).
  - Divisor D_X = 3*X_mean (10 bits), per channel.
  - Clear the quotients; iteration counter = 0.
- DIV (exactly 16 cycles): restoring division, one quotient bit per cycle, MSB first, all three channels in lockstep. Result Q_X = floor(N / D_X), 16 bits.
  - Overflow cannot occur: max value is 765*256/3 = 65280.
- Zero divisor: if X_mean == 0, K_X = 0xFFFF (saturate). Other channels are unaffected.
- DONE (1 cycle): load K_*_o from the quotients, assert finish_o for this cycle only, return to IDLE.
- Latency: finish_o is high in the 18th cycle after the cycle in which valid_i was sampled (IDLE→LOAD→16×DIV→DONE).
- K_*_o hold their values until the next DONE or reset.
- valid_i while not IDLE: ignored; no queuing.
- valid_i held high continuously: a new computation starts on the IDLE cycle following DONE. finish_o then pulses every 19 cycles.
- Input means are sampled only at capture; changes during computation have no effect.
- All-equal means (X=Y=Z=m, m>0): every gain = exactly 1.0 (1<<FRAC_BITS).

Optional Feature:
- Macro AWB_GAIN_CLIP_EN.
- Defined: each gain is clamped after division to max 4.0 = (4<<FRAC_BITS) before loading K_*_o; the zero-divisor case also yields 4.0 instead of 0xFFFF.
- Undefined: no clamping; full 16-bit quotient, with 0xFFFF for a zero mean.

Test Plan:
- Reset: assert rst 2 cycles with valid_i=1 -> all K_*_o = 0, finish_o = 0, no pulse during reset.
- Basic: R=50, G=100, B=50, valid_i one cycle -> finish_o pulse 18 cycles later; K_R_o = 341 (0x0155), K_G_o = 170 (0x00AA), K_B_o = 341; outputs hold afterwards.
- Unity: R=G=B=128 -> all gains 256 (0x0100). R=G=B=255 -> 256.
- Zero channel: R=0, G=90, B=30 -> K_R_o = 0xFFFF (clip build: 0x0400), K_G_o = 113, K_B_o = 341.
- Busy/back-to-back: valid_i held high while means change mid-computation -> the first result uses the means captured at start; the second finish_o comes 19 cycles after the first and uses the new means.
- Reset mid-DIV: rst asserted at DIV cycle 8 -> outputs 0, no finish_o pulse; a fresh start afterwards gives correct gains.
